// File: rtl/adder_switch_pkg.sv
// Shared encodings for the pipelined adder switch:
// commands, accumulator FSM states and lane indices.
package adder_switch_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'b000,
    CMD_FWD   = 3'b001,
    CMD_ADD   = 3'b010,
    CMD_VNL   = 3'b011,
    CMD_VNR   = 3'b100,
    CMD_VNB   = 3'b101,
    CMD_ACC   = 3'b110,
    CMD_FLUSH = 3'b111
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam int LANE_L = 1;
  localparam int LANE_R = 0;

endpackage

// File: rtl/pair_select_mux.sv
// Picks operands A (left index) and B (right index)
// from the input bus; indices past NUM_IN read as 0.
module pair_select_mux #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_IN = 2
) (
  input  logic [DATA_W*NUM_IN-1:0] i_data_bus,
  input  logic [2*SEL_IN-1:0]      i_sel,
  output logic [DATA_W-1:0]        o_a,
  output logic [DATA_W-1:0]        o_b
);

  logic [SEL_IN-1:0] w_sel_l;
  logic [SEL_IN-1:0] w_sel_r;

  assign w_sel_l = i_sel[2*SEL_IN-1:SEL_IN];
  assign w_sel_r = i_sel[SEL_IN-1:0];

  // Decode both indices; unmatched index leaves 0
  always_comb begin
    o_a = '0;
    o_b = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_sel_l == SEL_IN'(k))
        o_a = i_data_bus[k*DATA_W +: DATA_W];
      if (w_sel_r == SEL_IN'(k))
        o_b = i_data_bus[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/adder_switch_pipe.sv
// Pipelined adder switch: command stage with accumulator
// FSM, followed by a uniform-latency output delay line.
module adder_switch_pipe
  import adder_switch_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_IN      = 4,
  parameter int SEL_IN      = 2,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [DATA_W*NUM_IN-1:0] i_data_bus,
  input  logic [2:0]               i_cmd,
  input  logic [2*SEL_IN-1:0]      i_sel,
  input  logic                     i_last,
  output logic [2*DATA_W-1:0]      o_adder,
  output logic [1:0]               o_adder_valid,
  output logic [2*DATA_W-1:0]      o_vn,
  output logic [1:0]               o_vn_valid,
  output logic [CNT_W-1:0]         o_acc_cnt,
  output logic                     o_busy
);

  localparam int PW = 4*DATA_W + 4 + CNT_W + 1;
  localparam int LO = LANE_L*DATA_W;
  localparam int RO = LANE_R*DATA_W;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_acc_sum;
  logic [CNT_W-1:0]  w_cnt_inc;
  cmd_e              w_cmd;

  state_e            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic [2*DATA_W-1:0] r_adder;
  logic [1:0]          r_av;
  logic [2*DATA_W-1:0] r_vn;
  logic [1:0]          r_vv;
  logic [CNT_W-1:0]    r_acc_cnt;
  logic                r_busy;

  pair_select_mux #(
    .DATA_W (DATA_W),
    .NUM_IN (NUM_IN),
    .SEL_IN (SEL_IN)
  ) u_mux (
    .i_data_bus (i_data_bus),
    .i_sel      (i_sel),
    .o_a        (w_a),
    .o_b        (w_b)
  );

  assign w_cmd     = cmd_e'(i_cmd);
  assign w_sum     = w_a + w_b;
  assign w_acc_sum = r_acc + w_sum;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt
                   : r_cnt + CNT_W'(1);

  // Stage 1: command results and accumulator FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_adder   <= '0;
      r_av      <= '0;
      r_vn      <= '0;
      r_vv      <= '0;
      r_acc_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_av   <= '0;
      r_vv   <= '0;
      r_busy <= (r_state == ST_ACCUM);
      if (i_valid) begin
        unique case (w_cmd)
          CMD_NOP: ;
          CMD_FWD: begin
            r_adder <= {w_a, w_b};
            r_av    <= 2'b11;
          end
          CMD_ADD: begin
            r_adder <= {w_sum, w_sum};
            r_av    <= 2'b11;
          end
          CMD_VNL: begin
            r_vn[LO +: DATA_W]    <= w_a;
            r_vv                  <= 2'b10;
            r_adder[RO +: DATA_W] <= w_b;
            r_av                  <= 2'b01;
          end
          CMD_VNR: begin
            r_vn[RO +: DATA_W]    <= w_b;
            r_vv                  <= 2'b01;
            r_adder[LO +: DATA_W] <= w_a;
            r_av                  <= 2'b10;
          end
          CMD_VNB: begin
            r_vn <= {w_a, w_b};
            r_vv <= 2'b11;
          end
          CMD_ACC: begin
            if (r_state == ST_IDLE) begin
              if (i_last) begin
                r_adder   <= {w_sum, w_sum};
                r_av      <= 2'b11;
                r_acc_cnt <= CNT_W'(1);
              end else begin
                r_acc   <= w_sum;
                r_cnt   <= CNT_W'(1);
                r_state <= ST_ACCUM;
                r_busy  <= 1'b1;
              end
            end else begin
              if (i_last) begin
                r_adder   <= {w_acc_sum, w_acc_sum};
                r_av      <= 2'b11;
                r_acc_cnt <= w_cnt_inc;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
              end else begin
                r_acc <= w_acc_sum;
                r_cnt <= w_cnt_inc;
              end
            end
          end
          CMD_FLUSH: begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [PW-1:0] w_stage [PIPE_STAGES];

  assign w_stage[0] = {r_adder, r_av, r_vn,
                       r_vv, r_acc_cnt, r_busy};

  for (genvar g = 1; g < PIPE_STAGES; g++) begin : g_dly
    logic [PW-1:0] r_q;
    // Extra latency stage; reset drops in-flight beats
    always_ff @(posedge clk) begin
      if (rst) r_q <= '0;
      else     r_q <= w_stage[g-1];
    end
    assign w_stage[g] = r_q;
  end

  assign {o_adder, o_adder_valid, o_vn,
          o_vn_valid, o_acc_cnt, o_busy}
         = w_stage[PIPE_STAGES-1];

endmodule

// File: tb/tb_adder_switch_pipe.sv
// Bench for adder_switch_pipe: two configurations
// against a queue-based behavioural model.
module tb_adder_switch_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] bus;
  logic [2:0]  cmd;
  logic [5:0]  sel;
  logic        last;

  logic [15:0] adder0, vn0, adder1, vn1;
  logic [1:0]  av0, vv0, av1, vv1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  logic        busy0, busy1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  adder_switch_pipe #(
    .DATA_W(8), .NUM_IN(4), .SEL_IN(3),
    .PIPE_STAGES(2), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .rst(rst), .i_valid(valid),
    .i_data_bus(bus), .i_cmd(cmd), .i_sel(sel),
    .i_last(last), .o_adder(adder0),
    .o_adder_valid(av0), .o_vn(vn0),
    .o_vn_valid(vv0), .o_acc_cnt(cnt0),
    .o_busy(busy0)
  );

  adder_switch_pipe #(
    .DATA_W(8), .NUM_IN(4), .SEL_IN(3),
    .PIPE_STAGES(3), .CNT_W(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .i_valid(valid),
    .i_data_bus(bus), .i_cmd(cmd), .i_sel(sel),
    .i_last(last), .o_adder(adder1),
    .o_adder_valid(av1), .o_vn(vn1),
    .o_vn_valid(vv1), .o_acc_cnt(cnt1),
    .o_busy(busy1)
  );

  typedef struct packed {
    logic [7:0] al;
    logic [7:0] ar;
    logic [1:0] av;
    logic [7:0] vl;
    logic [7:0] vr;
    logic [1:0] vv;
    logic [7:0] cnt;
    logic       busy;
  } rec_t;

  logic [7:0] m_acc [2];
  int         m_cnt [2];
  bit         m_st  [2];
  rec_t       m_last[2];
  rec_t       q0[$];
  rec_t       q1[$];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] opnd(input int idx);
    logic [31:0] b;
    b = bus;
    if (idx >= 4) return 8'h00;
    return b[idx*8 +: 8];
  endfunction

  task automatic model_step(input int k,
                            input int cmax,
                            output rec_t r);
    logic [7:0] a, b, s;
    int n;
    a = opnd(int'(sel[5:3]));
    b = opnd(int'(sel[2:0]));
    s = a + b;
    r = m_last[k];
    r.av = 2'b00;
    r.vv = 2'b00;
    if (rst) begin
      r = '0;
      m_acc[k] = '0;
      m_cnt[k] = 0;
      m_st[k] = 1'b0;
    end else if (valid) begin
      case (cmd)
        3'd1: begin r.al = a; r.ar = b; r.av = 2'b11; end
        3'd2: begin r.al = s; r.ar = s; r.av = 2'b11; end
        3'd3: begin
          r.vl = a; r.vv = 2'b10;
          r.ar = b; r.av = 2'b01;
        end
        3'd4: begin
          r.vr = b; r.vv = 2'b01;
          r.al = a; r.av = 2'b10;
        end
        3'd5: begin r.vl = a; r.vr = b; r.vv = 2'b11; end
        3'd6: begin
          if (!m_st[k]) begin
            if (last) begin
              r.al = s; r.ar = s; r.av = 2'b11;
              r.cnt = 8'd1;
            end else begin
              m_acc[k] = s; m_cnt[k] = 1; m_st[k] = 1'b1;
            end
          end else begin
            n = (m_cnt[k] + 1 > cmax) ? cmax : m_cnt[k] + 1;
            if (!last) begin
              m_acc[k] = m_acc[k] + s;
              m_cnt[k] = n;
            end else begin
              r.al = m_acc[k] + s;
              r.ar = m_acc[k] + s;
              r.av = 2'b11;
              r.cnt = 8'(n);
              m_acc[k] = '0; m_cnt[k] = 0; m_st[k] = 1'b0;
            end
          end
        end
        3'd7: begin
          m_acc[k] = '0; m_cnt[k] = 0; m_st[k] = 1'b0;
        end
        default: ;
      endcase
    end
    r.busy = m_st[k];
    m_last[k] = r;
  endtask

  // Reference model advances on the same edge as the DUTs
  always @(posedge clk) begin
    rec_t r0, r1;
    model_step(0, 255, r0);
    model_step(1, 3, r1);
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) q0.push_back('0);
      for (int i = 0; i < 3; i++) q1.push_back('0);
    end else begin
      q0.push_back(r0);
      void'(q0.pop_front());
      q1.push_back(r1);
      void'(q1.pop_front());
    end
  end

  // Compare both DUTs against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("p2_adder", adder0, {q0[0].al, q0[0].ar});
      chk("p2_av", 16'(av0), 16'(q0[0].av));
      chk("p2_vn", vn0, {q0[0].vl, q0[0].vr});
      chk("p2_vv", 16'(vv0), 16'(q0[0].vv));
      chk("p2_cnt", 16'(cnt0), 16'(q0[0].cnt));
      chk("p2_busy", 16'(busy0), 16'(q0[0].busy));
      chk("p3_adder", adder1, {q1[0].al, q1[0].ar});
      chk("p3_av", 16'(av1), 16'(q1[0].av));
      chk("p3_vn", vn1, {q1[0].vl, q1[0].vr});
      chk("p3_vv", 16'(vv1), 16'(q1[0].vv));
      chk("p3_cnt", 16'(cnt1), 16'(q1[0].cnt));
      chk("p3_busy", 16'(busy1), 16'(q1[0].busy));
    end
  end

  task automatic beat(input bit v, input int c,
                      input int sl, input int sr,
                      input bit l);
    valid = v;
    cmd = 3'(c);
    sel = {3'(sl), 3'(sr)};
    last = l;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    bus = '0;
    cmd = '0;
    sel = '0;
    last = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("lit_rst_adder", adder0, 16'h0000);
    chk("lit_rst_valid", {12'h0, av0, vv1}, 16'h0);
    chk("lit_rst_busy", 16'(busy1), 16'h0);
    rst = 1'b0;
    bus = {8'd4, 8'd3, 8'd2, 8'd1};

    beat(1, 2, 3, 0, 0);
    beat(0, 0, 0, 0, 0);
    chk("lit_add", adder0, 16'h0505);
    chk("lit_add_v", 16'(av0), 16'h3);

    beat(1, 3, 2, 1, 0);
    beat(1, 5, 0, 3, 0);
    chk("lit_vnl_adder", adder0, 16'h0502);
    chk("lit_vnl_av", 16'(av0), 16'h1);
    chk("lit_vnl_vn", 16'(vn0[15:8]), 16'h3);
    chk("lit_vnl_vv", 16'(vv0), 16'h2);
    beat(0, 0, 0, 0, 0);
    chk("lit_vnb_vn", vn0, 16'h0104);
    chk("lit_vnb_vv", 16'(vv0), 16'h3);

    beat(1, 6, 4, 0, 0);
    beat(1, 6, 4, 1, 0);
    chk("lit_busy_hi", 16'(busy0), 16'h1);
    beat(1, 6, 4, 2, 0);
    beat(1, 6, 4, 3, 1);
    beat(0, 0, 0, 0, 0);
    chk("lit_acc_sum", adder0, 16'h0a0a);
    chk("lit_acc_cnt", 16'(cnt0), 16'd4);
    chk("lit_busy_lo", 16'(busy0), 16'h0);
    beat(0, 0, 0, 0, 0);
    chk("lit_cnt_sat", 16'(cnt1), 16'd3);

    beat(1, 6, 4, 0, 0);
    beat(1, 6, 4, 1, 0);
    beat(1, 1, 3, 2, 0);
    beat(1, 6, 4, 2, 1);
    chk("lit_fwd_mid", adder0, 16'h0403);
    beat(0, 0, 0, 0, 0);
    chk("lit_interleave", adder0, 16'h0606);
    chk("lit_interl_cnt", 16'(cnt0), 16'd3);

    beat(1, 6, 4, 3, 0);
    beat(1, 7, 0, 0, 0);
    beat(1, 6, 4, 0, 1);
    beat(0, 0, 0, 0, 0);
    chk("lit_flush", adder0, 16'h0101);
    chk("lit_flush_cnt", 16'(cnt0), 16'd1);

    bus = {8'hFF, 8'h03, 8'd2, 8'd1};
    beat(1, 2, 3, 2, 0);
    beat(0, 0, 0, 0, 0);
    chk("lit_wrap", adder0, 16'h0202);

    bus = {8'd4, 8'd3, 8'd2, 8'd1};
    beat(1, 6, 4, 3, 0);
    beat(1, 6, 4, 3, 0);
    rst = 1'b1;
    beat(1, 6, 4, 3, 1);
    rst = 1'b0;
    chk("lit_rst_av", {12'h0, av0, av1}, 16'h0);
    beat(1, 6, 4, 0, 1);
    chk("lit_rst_av2", {12'h0, av0, av1}, 16'h0);
    beat(0, 0, 0, 0, 0);
    chk("lit_rst_sum", adder0, 16'h0101);
    chk("lit_rst_cnt", 16'(cnt0), 16'd1);
    beat(0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      int c;
      rst = ($urandom_range(0, 99) == 0);
      bus = $urandom;
      c = $urandom_range(0, 7);
      if (c < 4) c = 6;
      else if (c == 7 && $urandom_range(0, 3) != 0)
        c = 6;
      else c = $urandom_range(0, 7);
      beat($urandom_range(0, 3) != 0, c,
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;
    repeat (4) beat(0, 0, 0, 0, 0);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_switch_pipe.md
# adder_switch_pipe

Parametrised, pipelined integer adder switch for the reduction network. It is the drop-in successor to the single-stage adder switch. Each cycle it selects two operands from an NUM_IN-wide input bus and then adds, forwards, or emits them as virtual-neuron (VN) outputs. New in this block: uniform configurable latency for every command, and a multi-cycle accumulate mode with a last-flag, element count and explicit flush.

## Interface
- DATA_W, 32: operand/result width.
- NUM_IN, 4: number of operands on i_data_bus.
- SEL_IN, 2: index width per operand, at least clog2(NUM_IN).
- PIPE_STAGES, 2: input-to-output latency in cycles, at least 1.
- CNT_W, 8: width of accumulate element count.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_data_bus  in  DATA_W*NUM_IN  operand k at bits [k*DATA_W +: DATA_W].
- i_cmd  in  3  command, sampled with i_valid.
- i_sel  in  2*SEL_IN  left index is the upper SEL_IN bits; right index is the lower SEL_IN bits.
- i_last  in  1  final beat of an accumulate group (cmd 110 only).
- o_adder  out  2*DATA_W  upper half is the left path, lower half is the right path.
- o_adder_valid  out  2  per-half valid, bit1 left, bit0 right.
- o_vn  out  2*DATA_W  VN outputs, upper half left, lower half right.
- o_vn_valid  out  2  per-half VN valid.
- o_acc_cnt  out  CNT_W  beats in the emitted accumulate group.
- o_busy  out  1  high while the accumulator holds a partial sum.

## Operation
- Operands: A = operand[left index], B = operand[right index]. An index ≥ NUM_IN selects 0.
- Arithmetic: unsigned two's-complement add, truncated to DATA_W (wraps, no saturation).
- Commands (only when i_valid=1):
  - 000 NOP: no outputs.
  - 001 forward: o_adder={A,B}, valid 11.
  - 010 add: o_adder={A+B,A+B}, valid 11.
  - 011 VN-left: o_vn left=A, vn_valid 10; o_adder right=B, adder_valid 01.
  - 100 VN-right: o_vn right=B, vn_valid 01; o_adder left=A, adder_valid 10.
  - 101 VN-both: o_vn={A,B}, vn_valid 11.
  - 110 accumulate: see the FSM below.
  - 111 flush: clears acc and count, goes to IDLE, no outputs.
- Accumulator FSM, states IDLE and ACCUM, registers acc (DATA_W) and cnt (CNT_W):
  - IDLE with 110 and !i_last: acc=A+B, cnt=1, go to ACCUM.
  - IDLE with 110 and i_last: emit A+B with o_acc_cnt=1, stay IDLE.
  - ACCUM with 110 and !i_last: acc=acc+A+B, cnt=cnt+1 (saturates at all-ones).
  - ACCUM with 110 and i_last: emit acc+A+B on both o_adder halves, adder_valid 11, o_acc_cnt=cnt+1 (saturating). Then clear acc and cnt and go to IDLE.
- Commands 000–101 in ACCUM are processed normally. acc, cnt and state are preserved, so groups may interleave with other traffic.
- i_valid=0: no state change; a bubble enters the pipeline.
- Output fields not written by a command hold their previous value. Valids are per-beat pulses.

## Timing
- Stage 1 registers the command result. The accumulator feedback closes in stage 1, so back-to-back 110 beats are supported at full rate.
- PIPE_STAGES-1 further register stages follow. Every output, valids included, appears exactly PIPE_STAGES cycles after the accepted beat, for all commands.
- o_busy and o_acc_cnt are aligned to the output (o_busy is the delayed FSM state).
- Reset (synchronous): all outputs 0, all pipeline valids 0, acc=0, cnt=0, FSM IDLE.
- Reset mid-accumulate or with beats in flight: the partial sum is discarded and in-flight beats never appear.
- Simultaneous rst and i_valid: rst wins and the beat is dropped.
- No backpressure: the downstream consumer must accept every valid pulse.

## Structure
- Shared package adder_switch_pkg holds:
  - the command encodings (CMD_NOP … CMD_FLUSH),
  - the FSM state type (ST_IDLE, ST_ACCUM),
  - lane index constants (LANE_L=1, LANE_R=0).
- Sub-module pair_select_mux (DATA_W, NUM_IN, SEL_IN) produces {A,B} combinationally, including the out-of-range → 0 rule.
- The delay line is a generate loop inside the top module.

## Test plan
- PIPE_STAGES=2, operands {4,3,2,1} (index 3..0), sel={3,0}, cmd 010 → o_adder={5,5}, valid 11, two cycles later.
- cmd 011, sel={2,1} → o_vn left=3, vn_valid 10, o_adder right=2, adder_valid 01. Then cmd 101, sel={0,3} → o_vn={1,4}, vn_valid 11.
- Four back-to-back 110 beats with A+B=1,2,3,4 and i_last on the fourth → single output 10, o_acc_cnt=4. o_busy falls with that output.
- Accumulate 2 beats, insert cmd 001, then a last beat → the forward output is correct and the accumulated sum is unaffected. Then flush mid-group → no output, next group starts from 0.
- Wrap and saturation: DATA_W=8, 0xFF+0x02 → 0x01. CNT_W=2, 5 beats → o_acc_cnt=3.
- Assert rst during an accumulate group with beats in flight → all valids stay 0 for PIPE_STAGES cycles and the next group's result excludes the old partial sum.
